// File: rtl/bsh_pkg.sv
// -----------------------------------------------------------------------------
// bsh_pkg
// Shared types for the pipelined barrel shifter.
//   bsh_mode_e  : operation select (SRL, SLL, SRA, ROR)
//   bsh_ctrl_t  : per-stage control payload (mode plus the amount MSB, which
//                 flags a shift of WIDTH or more and is resolved in the last
//                 stage)
// Configuration macro: BSH_ROTATE_EN (see bsh_stage).
// -----------------------------------------------------------------------------
package bsh_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        SRL = 2'b00,
        SLL = 2'b01,
        SRA = 2'b10,
        ROR = 2'b11
    } bsh_mode_e;

    typedef struct packed {
        bsh_mode_e mode;
        logic      ovf;
    } bsh_ctrl_t;

endpackage

// File: rtl/barrel_shifter_pipe_if.sv
// -----------------------------------------------------------------------------
// barrel_shifter_pipe_if
// Operation and result handshakes of the pipelined barrel shifter.
//   in_valid/in_ready   : operation handshake (in_data, in_amt, in_mode)
//   out_valid/out_ready : result handshake (out_data, out_zero)
// Modports: master drives operations and accepts results; slave is the shifter.
// -----------------------------------------------------------------------------
interface barrel_shifter_pipe_if #(
    parameter int WIDTH = 8
);
    localparam int SAW = $clog2(WIDTH) + 1;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SAW-1:0]   in_amt;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_zero;

    modport master (
        output in_valid, in_data, in_amt, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_zero
    );

    modport slave (
        input  in_valid, in_data, in_amt, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_zero
    );

endinterface

// File: rtl/bsh_stage.sv
// -----------------------------------------------------------------------------
// bsh_stage
// One registered stage of the barrel shifter. Stage IDX shifts by 2**IDX when
// the lowest remaining amount bit is set, then hands the remaining amount bits
// (shifted down by one) to the next stage. The last stage also resolves the
// overflow flag (amount >= WIDTH).
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   valid_i/ready_o            : upstream handshake
//   data_i, amt_i, ctrl_i      : upstream payload
//   valid_o/ready_i            : downstream handshake
//   data_o, amt_o, ctrl_o      : registered payload
// Configuration: BSH_ROTATE_EN enables rotate-right for mode ROR; without it
// ROR is handled as SRL and no wrap logic exists.
// -----------------------------------------------------------------------------
module bsh_stage
    import bsh_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int IDX   = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic [WIDTH-1:0]         data_i,
    input  logic [$clog2(WIDTH)-1:0] amt_i,
    input  bsh_ctrl_t                ctrl_i,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [WIDTH-1:0]         data_o,
    output logic [$clog2(WIDTH)-1:0] amt_o,
    output bsh_ctrl_t                ctrl_o
);

    localparam int LOG2W = $clog2(WIDTH);
    localparam int SH    = 1 << IDX;

    logic                 valid_reg;
    logic [WIDTH-1:0]     data_reg;
    logic [LOG2W-1:0]     amt_reg;
    bsh_ctrl_t            ctrl_reg;

    logic [WIDTH-1:0]     shifted;
    logic [WIDTH-1:0]     data_next;

    // The stage can take a new item when empty or when its item leaves now.
    assign ready_o = !valid_reg || ready_i;

    always_comb begin
        shifted = data_i;
        if (amt_i[0]) begin
            case (ctrl_i.mode)
                SLL:     shifted = data_i << SH;
                SRA:     shifted = $signed(data_i) >>> SH;
`ifdef BSH_ROTATE_EN
                ROR:     shifted = (data_i >> SH) | (data_i << (WIDTH - SH));
`endif
                default: shifted = data_i >> SH;
            endcase
        end
    end

    generate
        if (IDX == LOG2W - 1) begin : gen_last
            // Amount >= WIDTH: logical shifts clear, SRA keeps the sign
            // (still in the MSB, since arithmetic shifts never change it),
            // and a rotate simply ignores the MSB (amount mod WIDTH).
            always_comb begin
                data_next = shifted;
                if (ctrl_i.ovf) begin
                    case (ctrl_i.mode)
                        SRA:     data_next = {WIDTH{shifted[WIDTH-1]}};
`ifdef BSH_ROTATE_EN
                        ROR:     data_next = shifted;
`endif
                        default: data_next = '0;
                    endcase
                end
            end
        end else begin : gen_mid
            always_comb begin
                data_next = shifted;
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
            amt_reg   <= '0;
            ctrl_reg  <= '{mode: SRL, ovf: 1'b0};
        end else if (ready_o) begin
            valid_reg <= valid_i;
            if (valid_i) begin
                data_reg <= data_next;
                amt_reg  <= amt_i >> 1;
                ctrl_reg <= ctrl_i;
            end
        end
    end

    assign valid_o = valid_reg;
    assign data_o  = data_reg;
    assign amt_o   = amt_reg;
    assign ctrl_o  = ctrl_reg;

endmodule

// File: rtl/barrel_shifter_pipe.sv
// -----------------------------------------------------------------------------
// barrel_shifter_pipe
// Pipelined barrel shifter: LOG2W registered stages, one per amount bit (LSB
// stage first), one operation per cycle, latency LOG2W, full backpressure.
// Modes: SRL, SLL, SRA, ROR (ROR only with BSH_ROTATE_EN, otherwise SRL).
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset; empties the pipeline
//   bus   : barrel_shifter_pipe_if.slave (operation in, result out)
// Configuration macro: BSH_ROTATE_EN.
// -----------------------------------------------------------------------------
module barrel_shifter_pipe
    import bsh_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    barrel_shifter_pipe_if.slave        bus
);

    localparam int LOG2W = $clog2(WIDTH);
    localparam int SAW   = LOG2W + 1;

    logic             valid_chain [0:LOG2W];
    logic             ready_chain [0:LOG2W];
    logic [WIDTH-1:0] data_chain  [0:LOG2W];
    logic [LOG2W-1:0] amt_chain   [0:LOG2W];
    bsh_ctrl_t        ctrl_chain  [0:LOG2W];

    // Head of the chain: the amount MSB travels as the overflow flag.
    assign valid_chain[0] = bus.in_valid;
    assign data_chain[0]  = bus.in_data;
    assign amt_chain[0]   = bus.in_amt[LOG2W-1:0];
    assign ctrl_chain[0]  = '{mode: bsh_mode_e'(bus.in_mode), ovf: bus.in_amt[SAW-1]};

    // in_ready depends only on stage valids and out_ready, never on in_valid.
    assign bus.in_ready       = ready_chain[0];
    assign ready_chain[LOG2W] = bus.out_ready;

    generate
        for (genvar gi = 0; gi < LOG2W; gi++) begin : gen_stage
            bsh_stage #(
                .WIDTH (WIDTH),
                .IDX   (gi)
            ) u_stage (
                .clk     (clk),
                .rst_n   (rst_n),
                .valid_i (valid_chain[gi]),
                .ready_o (ready_chain[gi]),
                .data_i  (data_chain[gi]),
                .amt_i   (amt_chain[gi]),
                .ctrl_i  (ctrl_chain[gi]),
                .valid_o (valid_chain[gi+1]),
                .ready_i (ready_chain[gi+1]),
                .data_o  (data_chain[gi+1]),
                .amt_o   (amt_chain[gi+1]),
                .ctrl_o  (ctrl_chain[gi+1])
            );
        end
    endgenerate

    assign bus.out_valid = valid_chain[LOG2W];
    assign bus.out_data  = data_chain[LOG2W];
    // Gated by out_valid so an empty/reset pipeline reports 0 here.
    assign bus.out_zero  = valid_chain[LOG2W] && (data_chain[LOG2W] == '0);

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// -----------------------------------------------------------------------------
// tb_barrel_shifter_pipe
// Self-checking bench for barrel_shifter_pipe at WIDTH=8 (latency 3).
// Honours BSH_ROTATE_EN for the expected ROR results.
// -----------------------------------------------------------------------------
module tb_barrel_shifter_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    barrel_shifter_pipe_if #(.WIDTH(8)) bus ();

    barrel_shifter_pipe #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0] data;
        int         acc_cyc;
    } exp_t;

    exp_t       sb[$];
    int         n_assert = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         n_in     = 0;
    int         n_out    = 0;
    bit         lat_chk  = 1'b1;
    logic [7:0] pend_exp = 8'h00;

    // Reference: shift semantics computed directly with wide arithmetic.
    function automatic logic [7:0] ref_op(input logic [7:0] d, input int amt, input int mode);
        logic [15:0] w;
        int          a;
        a = (amt > 8) ? 8 : amt;
        w = {8'h00, d} >> a;
        if (mode == 1) begin
            w = {8'h00, d} << a;
        end else if (mode == 2) begin
            w = {{8{d[7]}}, d} >> a;
        end else if (mode == 3) begin
`ifdef BSH_ROTATE_EN
            w = {d, d} >> (amt % 8);
`else
            w = {8'h00, d} >> a;
`endif
        end
        return w[7:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: settle, score transfers happening at the coming edge, advance
    // to the next falling edge.
    task automatic tick(output bit acc);
        bit   in_x;
        bit   out_x;
        exp_t e;
        #1;
        in_x  = bus.in_valid && bus.in_ready;
        out_x = bus.out_valid && bus.out_ready;
        if (bus.out_valid) begin
            if (sb.size() == 0) begin
                check("spurious_out", 32'd1, 32'd0);
            end else begin
                e = sb[0];
                check("out_data", {24'h0, bus.out_data}, {24'h0, e.data});
                check("out_zero", {31'h0, bus.out_zero}, {31'h0, (e.data == 8'h00)});
                if (out_x) begin
                    void'(sb.pop_front());
                    n_out++;
                    $display("[%0d] result %02h", cyc, bus.out_data);
                    if (lat_chk) check("latency", cyc - e.acc_cyc, 32'd3);
                end
            end
        end
        if (in_x) begin
            e.data    = pend_exp;
            e.acc_cyc = cyc;
            sb.push_back(e);
            n_in++;
            $display("[%0d] accept d=%02h amt=%0d mode=%0d exp=%02h",
                     cyc, bus.in_data, bus.in_amt, bus.in_mode, pend_exp);
        end
        acc = in_x;
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] d, input logic [3:0] a, input logic [1:0] m,
                        input logic [7:0] exp, output int tries);
        bit acc;
        tries        = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_amt   = a;
        bus.in_mode  = m;
        pend_exp     = exp;
        do begin
            tick(acc);
            tries++;
        end while (!acc && tries < 50);
        if (!acc) check("accept_timeout", 32'd0, 32'd1);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        bit acc;
        int n;
        n = 0;
        bus.in_valid = 1'b0;
        while (sb.size() > 0 && n < 20) begin
            tick(acc);
            n++;
        end
        check("drain", sb.size(), 32'd0);
    endtask

    task automatic send_rand(output int tries);
        logic [7:0] d;
        logic [3:0] a;
        logic [1:0] m;
        d = 8'($urandom);
        a = 4'($urandom_range(0, 15));
        m = 2'($urandom_range(0, 3));
        send(d, a, m, ref_op(d, int'(a), int'(m)), tries);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         tries;
        bit         acc;
        logic [7:0] held;

        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.in_amt    = 4'h0;
        bus.in_mode   = 2'b00;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_in_ready",  {31'h0, bus.in_ready},  32'd1);
        check("rst_out_valid", {31'h0, bus.out_valid}, 32'd0);
        check("rst_out_data",  {24'h0, bus.out_data},  32'd0);
        check("rst_out_zero",  {31'h0, bus.out_zero},  32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Mode checks, first one accepted on the first edge after reset
        lat_chk = 1'b1;
        send(8'hB4, 4'd2, 2'b00, 8'h2D, tries);
        check("first_accept", tries, 32'd1);
        drain();
        send(8'h81, 4'd1, 2'b01, 8'h02, tries); drain();
        send(8'h90, 4'd3, 2'b10, 8'hF2, tries); drain();
`ifdef BSH_ROTATE_EN
        send(8'h81, 4'd1, 2'b11, 8'hC0, tries); drain();
`else
        send(8'h81, 4'd1, 2'b11, 8'h40, tries); drain();
`endif
        send(8'hB4, 4'd0, 2'b10, 8'hB4, tries); drain();

        // Overflow checks
        send(8'hFF, 4'd9,  2'b00, 8'h00, tries); drain();
        send(8'hFF, 4'd8,  2'b01, 8'h00, tries); drain();
        send(8'h80, 4'd12, 2'b10, 8'hFF, tries); drain();
        send(8'h7F, 4'd15, 2'b10, 8'h00, tries); drain();
`ifdef BSH_ROTATE_EN
        send(8'h81, 4'd9,  2'b11, 8'hC0, tries); drain();
`else
        send(8'h81, 4'd9,  2'b11, 8'h00, tries); drain();
`endif

        // Streaming: 16 back-to-back random operations
        for (int i = 0; i < 16; i++) begin
            send_rand(tries);
            check("stream_no_stall", tries, 32'd1);
        end
        drain();

        // Backpressure: out_ready low for 6 cycles while offering operations
        lat_chk       = 1'b0;
        bus.out_ready = 1'b0;
        held          = 8'h00;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'($urandom);
        bus.in_amt    = 4'($urandom_range(0, 15));
        bus.in_mode   = 2'($urandom_range(0, 3));
        pend_exp      = ref_op(bus.in_data, int'(bus.in_amt), int'(bus.in_mode));
        for (int i = 0; i < 6; i++) begin
            #1;
            check("bp_in_ready", {31'h0, bus.in_ready}, (i < 3) ? 32'd1 : 32'd0);
            if (i >= 4) check("bp_hold", {24'h0, bus.out_data}, {24'h0, held});
            held = bus.out_data;
            tick(acc);
            if (acc) begin
                bus.in_data = 8'($urandom);
                bus.in_amt  = 4'($urandom_range(0, 15));
                bus.in_mode = 2'($urandom_range(0, 3));
                pend_exp    = ref_op(bus.in_data, int'(bus.in_amt), int'(bus.in_mode));
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) send_rand(tries);
        drain();
        check("bp_count", n_out, n_in);

        // Reset mid-stream with 3 operations in flight
        lat_chk = 1'b1;
        for (int i = 0; i < 3; i++) send_rand(tries);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", {31'h0, bus.out_valid}, 32'd0);
        check("mid_rst_out_data",  {24'h0, bus.out_data},  32'd0);
        check("mid_rst_out_zero",  {31'h0, bus.out_zero},  32'd0);
        check("mid_rst_in_ready",  {31'h0, bus.in_ready},  32'd1);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("post_rst_idle", {31'h0, bus.out_valid}, 32'd0);
            tick(acc);
        end
        send(8'h01, 4'd3, 2'b01, 8'h08, tries);
        check("post_rst_accept", tries, 32'd1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/barrel_shifter_pipe.md
BARREL_SHIFTER_PIPE -- requirements
Module: barrel_shifter_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width; legal values are powers of two from 4 to 64.
REQ-002 SHALL derive localparam LOG2W = log2(WIDTH), the number of shift stages, and SAW = LOG2W+1, the shift-amount width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  input operation valid.
REQ-006 in_ready  output  1  block can accept an operation this cycle.
REQ-007 in_data  input  WIDTH  operand.
REQ-008 in_amt  input  SAW  shift amount, 0 to 2*WIDTH-1.
REQ-009 in_mode  input  2  operation: 00 SRL, 01 SLL, 10 SRA, 11 ROR.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  downstream accepts the result.
REQ-012 out_data  output  WIDTH  shifted result.
REQ-013 out_zero  output  1  high when out_data is all zeros; qualified by out_valid.

Function
REQ-014 An input transfer SHALL occur when in_valid && in_ready; an output transfer SHALL occur when out_valid && out_ready.
REQ-015 The pipeline SHALL have LOG2W registered stages; stage k conditionally shifts by 2^k according to amount bit k, LSB stage first.
REQ-016 Each stage SHALL carry valid, data, mode, remaining amount bits and the amount MSB ("overflow") to the next stage.
REQ-017 Latency SHALL be exactly LOG2W cycles from input transfer to out_valid when unstalled; throughput SHALL be 1 operation per cycle.
REQ-018 Stage k SHALL load when it is empty or its contents move on in the same cycle; in_ready SHALL be the stage-0 load condition, with no combinational path from in_valid to in_ready.
REQ-019 While out_valid && !out_ready, out_data, out_zero and all stage contents SHALL hold; no operation SHALL be lost or duplicated.
REQ-020 SRL and SLL SHALL zero-fill; SRA SHALL replicate in_data[WIDTH-1]; ROR SHALL rotate right.
REQ-021 If in_amt >= WIDTH: SRL and SLL SHALL produce 0; SRA SHALL produce all copies of the sign bit; ROR SHALL use in_amt mod WIDTH. The overflow correction SHALL be applied in the last stage.
REQ-022 in_amt = 0 SHALL return in_data unchanged in every mode.
REQ-023 Operations SHALL exit in acceptance order; simultaneous input and output transfers on a full pipeline SHALL both proceed.

Reset
REQ-024 Asserting rst_n low SHALL immediately clear all stage valids, out_valid, out_data and out_zero to 0, including mid-operation; in-flight operations SHALL be discarded.
REQ-025 in_ready SHALL be 1 during and after reset because the pipeline is empty.
REQ-026 The first input transfer SHALL be possible on the first rising edge after rst_n deasserts.

Configuration
REQ-027 With macro BSH_ROTATE_EN defined, mode 11 SHALL perform ROR as specified.
REQ-028 Without BSH_ROTATE_EN, mode 11 SHALL behave exactly as SRL, and no rotate wrap logic SHALL be synthesised.

Structure
REQ-029 Package bsh_pkg SHALL hold the mode typedef (enum SRL, SLL, SRA, ROR) and the stage-payload struct typedef.
REQ-030 Sub-module bsh_stage SHALL implement one registered shift stage, parametrised by WIDTH and stage index, with valid/ready; the top SHALL instantiate LOG2W of them.

Verification (WIDTH=8, latency 3)
REQ-031 Mode checks: SRL 8'hB4 by 2 -> 8'h2D; SLL 8'h81 by 1 -> 8'h02; SRA 8'h90 by 3 -> 8'hF2; ROR 8'h81 by 1 -> 8'hC0; each appears 3 cycles after acceptance.
REQ-032 Overflow checks: SRL 8'hFF by 9 -> 8'h00 with out_zero=1; SRA 8'h80 by 12 -> 8'hFF; ROR 8'h81 by 9 -> 8'hC0. Without BSH_ROTATE_EN, ROR 8'h81 by 1 -> 8'h40.
REQ-033 Streaming: 16 back-to-back random operations with out_ready=1 -> 16 results on consecutive cycles, in order, matching the reference model.
REQ-034 Backpressure: out_ready held 0 for 6 cycles while streaming -> in_ready falls after 3 accepts; out_data holds; all results arrive in order after release, with none lost or duplicated.
REQ-035 Reset mid-stream: rst_n pulsed low with 3 operations in flight -> out_valid=0 and out_data=0 immediately; no stale result appears afterwards; a new operation 8'h01 SLL by 3 -> 8'h08 after 3 cycles.
